uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter. Successor to the fixed 8N1 transmitter, with an internal baud divider, configurable data width, optional parity, 1 or 2 stop bits, and a valid/ready input handshake that supports gap-free back-to-back frames. It runs on the system clock, not a pre-divided baud clock, and sits between a byte/word source (FIFO or CPU register) and the tx pin.

Parameters:
CLK_DIV, 16, system clocks per serial bit; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
MSB_FIRST, 0, bit order: 0 = LSB first (standard UART), 1 = MSB first.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
en  input  1  enables acceptance of new frames; does not abort a frame in progress.
in_valid  input  1  source has a word on in_data.
in_ready  output  1  transmitter can accept a word this cycle.
in_data  input  DATA_BITS  word to send.
out  output  1  serial tx line; idles high.
busy  output  1  high while a frame is on the line.
done  output  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset (reset=1 at a posedge):
  - state=IDLE, out=1, busy=0, done=0.
  - Shift register, bit counter and divider counter are all 0.
  - in_ready=0 while reset is high.
  - Reset mid-frame aborts immediately: out returns to 1 on the next cycle and no done pulse is produced.
- Handshake:
  - in_ready is combinational: en & ~reset & (state==IDLE | last_cycle_of_frame).
  - A word is accepted on a posedge where in_valid & in_ready.
  - in_data is latched into the shift register; the parity bit is computed and latched at the same edge.
- Frame timing (accept at edge T):
  - out=0 (start bit) from T+1.
  - Every bit is held for exactly CLK_DIV cycles.
  - Sequence: START, DATA (DATA_BITS bits), PARITY (if PARITY!=0), STOP (STOP_BITS bits, out=1).
  - Frame length F = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles.
- Divider:
  - Counts 0..CLK_DIV-1.
  - It is cleared on accept, so every frame starts phase-aligned.
  - The bit advances when the count reaches CLK_DIV-1.
- Parity: the parity bit is the XOR of the data bits for even parity, and its inverse for odd parity. Total ones in data+parity is even (even mode) or odd (odd mode).
- busy: 1 from T+1 through the final cycle of the last stop bit.
- done: a single-cycle pulse, 1 in the cycle after the last stop bit cycle completes.
- Back-to-back frames:
  - If a new word is accepted in last_cycle_of_frame, the next start bit follows immediately, with no idle cycle.
  - busy stays 1 across the boundary.
  - done still pulses for the completed frame.
- en:
  - en=0 blocks new accepts.
  - A frame in progress always completes.
  - Deasserting en during the last cycle of the frame prevents a back-to-back accept.
- in_valid held without en: no effect; the word is not consumed.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START on a back-to-back accept.
  - In DATA, the bit counter runs 0..DATA_BITS-1.
  - In STOP, the counter runs 0..STOP_BITS-1.
  - An illegal state encoding recovers to IDLE with out=1.
- Width rules:
  - The divider counter is $clog2(CLK_DIV) bits.
  - The bit counter is $clog2(DATA_BITS) bits, wide enough to hold DATA_BITS-1.
  - No truncation warnings are permitted.
- Parameter checks: out-of-range parameters raise an elaboration-time error.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT);
  - parity mode constants PARITY_NONE, PARITY_ODD, PARITY_EVEN;
  - a frame_len(DATA_BITS, PARITY, STOP_BITS) function for benches.
- One sub-module, uart_baud_tick:
  - Parameter: CLK_DIV.
  - Inputs: clear, run.
  - Output: a tick pulse when the count wraps.
  - The future receiver will reuse it.

Test Plan:
- CLK_DIV=4, 8N1, send 0xA5 -> from T+1 out = 0, 1,0,1,0,0,1,0,1 (LSB first), then 1, with each level held 4 cycles; busy high for 40 cycles; done pulses once at T+41.
- CLK_DIV=4, DATA_BITS=8, PARITY=2 (even), send 0xA5 -> parity bit 0; PARITY=1 (odd), send 0xA5 -> parity bit 1; send 0x01 with even parity -> parity bit 1; frame is 44 cycles.
- CLK_DIV=2, DATA_BITS=7, STOP_BITS=2, MSB_FIRST=1, send 7'h41 -> data order 1,0,0,0,0,0,1; two stop bits cover 4 cycles; frame is 20 cycles.
- in_valid held high continuously with 0x55 then 0xAA -> second start bit begins the cycle after the first frame's last stop cycle; no idle gap; busy never drops; two done pulses.
- Assert reset at cycle 10 of a 40-cycle frame -> next cycle out=1, busy=0, no done pulse; a new word is accepted once reset=0, and its frame is correct.
- en=0 with in_valid=1 -> in_ready=0, out stays 1, nothing sent. Drop en mid-frame -> the frame completes normally and the following word is not accepted until en=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: FSM state encoding, parity
// mode constants and a frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Frame length in bit periods; multiply by CLK_DIV for clock cycles.
  function automatic int frame_len(input int data_bits, input int parity,
                                   input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready word handshake between a word source and the UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 while run is high and pulses tick
// on the wrap cycle. Shared with the receiver.
module uart_baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int              CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // tick ignores clear so the ready path in the transmitter has no loop
  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with internal baud divider, optional parity,
// 1/2 stop bits and a gap-free valid/ready word input.
//
// state      | meaning
// IDLE       | line high, waiting for a word
// START_BIT  | driving the start bit (0)
// DATA_BITS  | shifting data bits out of shift_q[0]
// PARITY_BIT | driving the latched parity bit
// STOP_BIT   | driving stop bit(s) (1); last cycle may accept the next word
module uart_tx_param #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  uart_tx_param_if.slave   in_if,
  output logic             out,
  output logic             busy,
  output logic             done
);
  import uart_pkg::*;

  localparam int            BW        = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PARITY_NONE);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("uart_tx_param: CLK_DIV out of range 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS out of range 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_msb_first
    $error("uart_tx_param: MSB_FIRST must be 0 or 1");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 par_q, par_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] load_word;
  logic                 tick, last_cycle, accept;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .run   (state_q != IDLE),
    .tick  (tick)
  );

  assign last_cycle     = tick && (state_q == STOP_BIT) && (bit_q == LAST_STOP);
  assign in_if.in_ready = en && !reset && ((state_q == IDLE) || last_cycle);
  assign accept         = in_if.in_valid && in_if.in_ready;

  // The shift register always emits bit 0, so MSB-first words are reversed on load
  always_comb begin
    load_word = in_if.in_data;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < DATA_BITS; i++) begin
        load_word[i] = in_if.in_data[DATA_BITS-1-i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: ;
      START_BIT: begin
        if (tick) begin
          state_d = uart_pkg::DATA_BITS;
          bit_d   = '0;
        end
      end
      uart_pkg::DATA_BITS: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = HAS_PAR ? PARITY_BIT : STOP_BIT;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY_BIT: begin
        if (tick) begin
          state_d = STOP_BIT;
          bit_d   = '0;
        end
      end
      STOP_BIT: begin
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            state_d = IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = START_BIT;
      shift_d = load_word;
      bit_d   = '0;
      par_d   = (^in_if.in_data) ^ (PARITY == PARITY_ODD);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    case (state_q)
      START_BIT:           out = 1'b0;
      uart_pkg::DATA_BITS: out = shift_q[0];
      PARITY_BIT:          out = par_q;
      default:             out = 1'b1;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter sets driven from a table
// of hand-computed frames plus back-to-back, reset-abort and enable sequences.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int DIV_C [4] = '{4, 4, 4, 2};

  typedef struct {
    int         dut;
    logic [8:0] word;
    int         nb;
    logic [11:0] bits;   // frame levels in time order, first level at bit nb-1
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] en_r, valid_r;
  logic [8:0] data_r [4];
  logic [3:0] out_w, busy_w, done_w, ready_w;
  int         checks = 0;
  int         errors = 0;
  vec_t       vecs [8];

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_param_if #(.DATA_BITS(7)) if3 ();

  assign if0.in_valid = valid_r[0];
  assign if1.in_valid = valid_r[1];
  assign if2.in_valid = valid_r[2];
  assign if3.in_valid = valid_r[3];
  assign if0.in_data  = data_r[0][7:0];
  assign if1.in_data  = data_r[1][7:0];
  assign if2.in_data  = data_r[2][7:0];
  assign if3.in_data  = data_r[3][6:0];
  assign ready_w      = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1), .MSB_FIRST(0))
    u0 (.clk(clk), .reset(reset), .en(en_r[0]), .in_if(if0.slave),
        .out(out_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1), .MSB_FIRST(0))
    u1 (.clk(clk), .reset(reset), .en(en_r[1]), .in_if(if1.slave),
        .out(out_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1), .MSB_FIRST(0))
    u2 (.clk(clk), .reset(reset), .en(en_r[2]), .in_if(if2.slave),
        .out(out_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx_param #(.CLK_DIV(2), .DATA_BITS(7), .PARITY(PARITY_NONE), .STOP_BITS(2), .MSB_FIRST(1))
    u3 (.clk(clk), .reset(reset), .en(en_r[3]), .in_if(if3.slave),
        .out(out_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_cycle(input int d, input logic o, input logic b, input logic dn,
                           input string tag);
    @(negedge clk);
    chk({tag, " out"},  {31'd0, out_w[d]},  {31'd0, o});
    chk({tag, " busy"}, {31'd0, busy_w[d]}, {31'd0, b});
    chk({tag, " done"}, {31'd0, done_w[d]}, {31'd0, dn});
  endtask

  task automatic accept(input int d, input logic [8:0] w, input string tag);
    data_r[d]  = w;
    valid_r[d] = 1'b1;
    #1;
    chk({tag, " in_ready"}, {31'd0, ready_w[d]}, 32'd1);
    @(posedge clk);
    #1 valid_r[d] = 1'b0;
  endtask

  task automatic frame_cycles(input int d, input int nb, input logic [11:0] bits,
                              input int from_c, input int to_c, input string tag);
    for (int c = from_c; c <= to_c; c++) begin
      chk_cycle(d, bits[nb - 1 - (c - 1) / DIV_C[d]], 1'b1, 1'b0, tag);
    end
  endtask

  task automatic frame_end(input int d, input string tag);
    chk_cycle(d, 1'b1, 1'b0, 1'b1, {tag, " end"});
    chk_cycle(d, 1'b1, 1'b0, 1'b0, {tag, " post"});
  endtask

  initial begin
    vecs[0] = '{0, 9'h0A5, 10, 12'b00_0101001011};
    vecs[1] = '{0, 9'h03C, 10, 12'b00_0001111001};
    vecs[2] = '{1, 9'h0A5, 11, 12'b0_01010010101};
    vecs[3] = '{1, 9'h001, 11, 12'b0_01000000011};
    vecs[4] = '{2, 9'h0A5, 11, 12'b0_01010010111};
    vecs[5] = '{2, 9'h0FF, 11, 12'b0_01111111111};
    vecs[6] = '{3, 9'h041, 10, 12'b00_0100000111};
    vecs[7] = '{3, 9'h02A, 10, 12'b00_0010101011};

    reset   = 1'b1;
    en_r    = 4'hF;
    valid_r = 4'hF;
    for (int d = 0; d < 4; d++) data_r[d] = 9'h0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("reset out",      {31'd0, out_w[d]},   32'd1);
      chk("reset busy",     {31'd0, busy_w[d]},  32'd0);
      chk("reset done",     {31'd0, done_w[d]},  32'd0);
      chk("reset in_ready", {31'd0, ready_w[d]}, 32'd0);
    end
    valid_r = 4'h0;
    reset   = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      accept(vecs[v].dut, vecs[v].word, $sformatf("vec%0d", v));
      frame_cycles(vecs[v].dut, vecs[v].nb, vecs[v].bits, 1,
                   vecs[v].nb * DIV_C[vecs[v].dut], $sformatf("vec%0d", v));
      frame_end(vecs[v].dut, $sformatf("vec%0d", v));
    end

    // back-to-back: valid held across the frame boundary
    data_r[0]  = 9'h055;
    valid_r[0] = 1'b1;
    @(posedge clk);
    #1 data_r[0] = 9'h0AA;
    frame_cycles(0, 10, 12'b00_0101010101, 1, 40, "b2b first");
    #1 chk("b2b last-cycle in_ready", {31'd0, ready_w[0]}, 32'd1);
    chk_cycle(0, 1'b0, 1'b1, 1'b1, "b2b boundary");
    valid_r[0] = 1'b0;
    frame_cycles(0, 10, 12'b00_0010101011, 2, 40, "b2b second");
    frame_end(0, "b2b second");

    // reset aborts a frame after 10 cycles
    accept(0, 9'h0A5, "rst pre");
    frame_cycles(0, 10, 12'b00_0101001011, 1, 10, "rst pre");
    reset = 1'b1;
    chk_cycle(0, 1'b1, 1'b0, 1'b0, "rst abort");
    chk("rst in_ready", {31'd0, ready_w[0]}, 32'd0);
    reset = 1'b0;
    chk_cycle(0, 1'b1, 1'b0, 1'b0, "rst idle");
    accept(0, 9'h03C, "rst post");
    frame_cycles(0, 10, 12'b00_0001111001, 1, 40, "rst post");
    frame_end(0, "rst post");

    // en low blocks accepts
    en_r[0]    = 1'b0;
    valid_r[0] = 1'b1;
    data_r[0]  = 9'h0FF;
    for (int c = 0; c < 8; c++) begin
      chk_cycle(0, 1'b1, 1'b0, 1'b0, "en0 idle");
      chk("en0 in_ready", {31'd0, ready_w[0]}, 32'd0);
    end
    valid_r[0] = 1'b0;
    en_r[0]    = 1'b1;

    // en dropped mid-frame: frame completes, pending word waits for en
    accept(0, 9'h0A5, "endrop");
    en_r[0]    = 1'b0;
    valid_r[0] = 1'b1;
    data_r[0]  = 9'h03C;
    frame_cycles(0, 10, 12'b00_0101001011, 1, 40, "endrop");
    chk("endrop last in_ready", {31'd0, ready_w[0]}, 32'd0);
    chk_cycle(0, 1'b1, 1'b0, 1'b1, "endrop end");
    for (int c = 0; c < 4; c++) begin
      chk_cycle(0, 1'b1, 1'b0, 1'b0, "endrop hold");
    end
    en_r[0] = 1'b1;
    accept(0, 9'h03C, "endrop resume");
    frame_cycles(0, 10, 12'b00_0001111001, 1, 40, "endrop resume");
    frame_end(0, "endrop resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
